// File: rtl/fsk_mod.sv
// Binary FSK modulator: one bit per BIT_CYCLES clocks, square-wave carrier
// whose half-period is HALF1 for a 1 and HALF0 for a 0, phase-continuous
// across back-to-back symbols and parked at 0 when no data is queued.
//
// Ports:
//   clk_in     : system clock, rising edge
//   rst        : synchronous active-high reset
//   din_valid  : upstream bit on din is valid
//   din        : data bit
//   din_ready  : a bit is accepted this cycle when din_valid is also high
//   fsk_out    : registered modulated carrier
//   tx_active  : high while a symbol is being sent
//   bit_strobe : one-cycle pulse in the last cycle of each symbol
module fsk_mod #(
  parameter int HALF0      = 16384,
  parameter int HALF1      = 8192,
  parameter int BIT_CYCLES = 262144,
  parameter int CW         = 24
) (
  input  logic clk_in,
  input  logic rst,
  input  logic din_valid,
  input  logic din,
  output logic din_ready,
  output logic fsk_out,
  output logic tx_active,
  output logic bit_strobe
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam logic [CW-1:0] H0_LAST  = CW'(HALF0 - 1);
  localparam logic [CW-1:0] H1_LAST  = CW'(HALF1 - 1);
  localparam logic [CW-1:0] SYM_LAST = CW'(BIT_CYCLES - 1);

  state_t        state;
  logic          cur_bit;
  logic [CW-1:0] car_cnt;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] half_last;
  logic          car_wrap;
  logic          sym_last;

  assign half_last = cur_bit ? H1_LAST : H0_LAST;
  assign car_wrap  = (car_cnt == half_last);
  assign sym_last  = (state == SEND) && (bit_cnt == SYM_LAST);

  // Handshake/status outputs depend on registered state only.
  assign din_ready  = (state == IDLE) || sym_last;
  assign bit_strobe = sym_last;
  assign tx_active  = (state == SEND);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state   <= IDLE;
      cur_bit <= 1'b0;
      car_cnt <= '0;
      bit_cnt <= '0;
      fsk_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          car_cnt <= '0;
          bit_cnt <= '0;
          fsk_out <= 1'b0;
          if (din_valid) begin
            cur_bit <= din;
            state   <= SEND;
          end
        end
        SEND: begin
          if (car_wrap) begin
            car_cnt <= '0;
            fsk_out <= ~fsk_out;
          end else begin
            car_cnt <= car_cnt + 1'b1;
          end
          bit_cnt <= bit_cnt + 1'b1;
          if (sym_last) begin
            car_cnt <= '0;
            bit_cnt <= '0;
            if (din_valid) begin
              // Keep the carrier level (incl. any toggle) for continuity.
              cur_bit <= din;
            end else begin
              // Underrun: park the line low, overriding a due toggle.
              state   <= IDLE;
              fsk_out <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_mod.sv
// Directed self-checking bench for fsk_mod with HALF0=4, HALF1=2,
// BIT_CYCLES=16; outputs are captured #1 after each edge and compared.
module tb_fsk_mod;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic din_ready;
  logic fsk_out;
  logic tx_active;
  logic bit_strobe;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] cap_fsk;
  logic [63:0] cap_tx;
  logic [63:0] cap_stb;
  logic [63:0] cap_rdy;

  logic [63:0] exp_fsk;
  logic [63:0] exp_tx;
  logic [63:0] exp_stb;
  logic [63:0] exp_rdy;

  localparam int N = 40;

  fsk_mod #(
    .HALF0(4),
    .HALF1(2),
    .BIT_CYCLES(16),
    .CW(8)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .din_valid(din_valid),
    .din(din),
    .din_ready(din_ready),
    .fsk_out(fsk_out),
    .tx_active(tx_active),
    .bit_strobe(bit_strobe)
  );

  always #5 clk_in = ~clk_in;

  // Index e holds the outputs sampled #1 after edge e; schedule bit e is
  // the input value driven right after edge e.
  task automatic capture(input int n, input logic [63:0] vs,
                         input logic [63:0] ds, input logic [63:0] rs);
    cap_fsk = '0;
    cap_tx  = '0;
    cap_stb = '0;
    cap_rdy = '0;
    for (int e = 0; e < n; e++) begin
      @(posedge clk_in);
      #1;
      cap_fsk[e] = fsk_out;
      cap_tx[e]  = tx_active;
      cap_stb[e] = bit_strobe;
      cap_rdy[e] = din_ready;
      din_valid  = vs[e];
      din        = ds[e];
      rst        = rs[e];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'($urandom_range(0, 1));
      din       = 1'($urandom_range(0, 1));
      @(posedge clk_in);
      #1;
      n_cmp++;
      if ({fsk_out, tx_active, bit_strobe, din_ready} !== 4'b0001) begin
        n_bad++;
        $display("FAIL reset[%0d] got f/t/s/r=%b%b%b%b want 0001",
                 i, fsk_out, tx_active, bit_strobe, din_ready);
      end
    end
    rst       = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  task automatic test_single(input logic b);
    din_valid = 1'b1;
    din       = b;
    capture(N, 64'd0, 64'd0, 64'd0);
    exp_fsk = '0;
    exp_tx  = '0;
    exp_stb = '0;
    exp_rdy = '0;
    if (b) begin
      exp_fsk[3:2]   = '1;
      exp_fsk[7:6]   = '1;
      exp_fsk[11:10] = '1;
      exp_fsk[15:14] = '1;
    end else begin
      exp_fsk[7:4]   = '1;
      exp_fsk[15:12] = '1;
    end
    exp_tx[15:0]  = '1;
    exp_stb[15]   = 1'b1;
    exp_rdy[39:15] = '1;
    n_cmp++;
    if (cap_fsk !== exp_fsk) begin
      n_bad++;
      $display("FAIL single%0b fsk got %h want %h", b, cap_fsk, exp_fsk);
    end
    n_cmp++;
    if (cap_tx !== exp_tx) begin
      n_bad++;
      $display("FAIL single%0b tx got %h want %h", b, cap_tx, exp_tx);
    end
    n_cmp++;
    if (cap_stb !== exp_stb) begin
      n_bad++;
      $display("FAIL single%0b strobe got %h want %h", b, cap_stb, exp_stb);
    end
    n_cmp++;
    if (cap_rdy !== exp_rdy) begin
      n_bad++;
      $display("FAIL single%0b ready got %h want %h", b, cap_rdy, exp_rdy);
    end
  endtask

  // Bit 1 then bit 0; vs controls when the second bit is offered.
  task automatic test_pair(input string name, input logic [63:0] vs);
    din_valid = 1'b1;
    din       = 1'b1;
    capture(N, vs, 64'd0, 64'd0);
    exp_fsk = '0;
    exp_tx  = '0;
    exp_stb = '0;
    exp_rdy = '0;
    exp_fsk[3:2]   = '1;
    exp_fsk[7:6]   = '1;
    exp_fsk[11:10] = '1;
    exp_fsk[15:14] = '1;
    exp_fsk[23:20] = '1;
    exp_fsk[31:28] = '1;
    exp_tx[31:0]   = '1;
    exp_stb[15]    = 1'b1;
    exp_stb[31]    = 1'b1;
    exp_rdy[15]    = 1'b1;
    exp_rdy[39:31] = '1;
    n_cmp++;
    if (cap_fsk !== exp_fsk) begin
      n_bad++;
      $display("FAIL %s fsk got %h want %h", name, cap_fsk, exp_fsk);
    end
    n_cmp++;
    if (cap_tx !== exp_tx) begin
      n_bad++;
      $display("FAIL %s tx got %h want %h", name, cap_tx, exp_tx);
    end
    n_cmp++;
    if (cap_stb !== exp_stb) begin
      n_bad++;
      $display("FAIL %s strobe got %h want %h", name, cap_stb, exp_stb);
    end
    n_cmp++;
    if (cap_rdy !== exp_rdy) begin
      n_bad++;
      $display("FAIL %s ready got %h want %h", name, cap_rdy, exp_rdy);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vs;
    vs = '0;
    vs[15:0] = '1;
    test_pair("b2b", vs);
  endtask

  task automatic test_backpressure();
    logic [63:0] vs;
    vs = '0;
    vs[15:4] = '1;
    test_pair("bp", vs);
  endtask

  task automatic test_reset_mid();
    logic [63:0] vs;
    logic [63:0] rs;
    vs = '0;
    rs = '0;
    vs[8] = 1'b1;
    rs[6] = 1'b1;
    din_valid = 1'b1;
    din       = 1'b1;
    capture(N, vs, '1, rs);
    exp_fsk = '0;
    exp_tx  = '0;
    exp_stb = '0;
    exp_rdy = '0;
    exp_fsk[3:2]   = '1;
    exp_fsk[6]     = 1'b1;
    exp_fsk[12:11] = '1;
    exp_fsk[16:15] = '1;
    exp_fsk[20:19] = '1;
    exp_fsk[24:23] = '1;
    exp_tx[6:0]    = '1;
    exp_tx[24:9]   = '1;
    exp_stb[24]    = 1'b1;
    exp_rdy[8:7]   = '1;
    exp_rdy[39:24] = '1;
    n_cmp++;
    if (cap_fsk !== exp_fsk) begin
      n_bad++;
      $display("FAIL rstmid fsk got %h want %h", cap_fsk, exp_fsk);
    end
    n_cmp++;
    if (cap_tx !== exp_tx) begin
      n_bad++;
      $display("FAIL rstmid tx got %h want %h", cap_tx, exp_tx);
    end
    n_cmp++;
    if (cap_stb !== exp_stb) begin
      n_bad++;
      $display("FAIL rstmid strobe got %h want %h", cap_stb, exp_stb);
    end
    n_cmp++;
    if (cap_rdy !== exp_rdy) begin
      n_bad++;
      $display("FAIL rstmid ready got %h want %h", cap_rdy, exp_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_single(1'b1);
    test_single(1'b0);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
